// File: rtl/key_event_tx_if.sv
// Key-code stream between the button front-end and the recency tracker.
// Producer drives valid/code, consumer drives ready; a transfer happens on valid && ready.
interface key_event_tx_if;
    logic       valid;
    logic       ready;
    logic [2:0] code;

    modport master (output valid, output code, input ready);
    modport slave  (input valid, input code, output ready);
endinterface

// File: rtl/key_event_tx.sv
// Four-button synchronizer/debouncer feeding a FWFT key-code FIFO and a valid/ready stream.
// Optional macro KEY_REPEAT_EN adds auto-repeat while exactly one button is held.
module key_event_tx #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int FIFO_DEPTH      = 4,
    parameter int REPEAT_CYCLES   = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  b1,
    input  logic                  b2,
    input  logic                  b3,
    input  logic                  b4,
    input  logic                  ovf_clr,
    key_event_tx_if.master        evt,
    output logic [4:0]            level,
    output logic                  ovf
);

    localparam int             DW      = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int             AW      = $clog2(FIFO_DEPTH);
    localparam logic [DW-1:0]  DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [4:0]     DEPTH5  = 5'(FIFO_DEPTH);

    logic [3:0]    btn_raw;
    logic [3:0]    sync1_q, sync2_q;
    logic [3:0]    stable_q, stable_d;
    logic [3:0]    press_q, press_d;
    logic [3:0]    pending_q, pending_d;
    logic [DW-1:0] cnt_q [4];
    logic [DW-1:0] cnt_d [4];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [4:0]    level_q, level_d;
    logic          ovf_q, ovf_d;
    logic [2:0]    fifo_mem [FIFO_DEPTH];
    logic [3:0]    grant, set_req, rpt_set;
    logic          wr_en, pop, drop, full, valid_int;
    logic [2:0]    wr_code;

    assign btn_raw = {b4, b3, b2, b1};

    // Counter only advances while the synchronized input disagrees with the stable bit.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            stable_d[i] = stable_q[i];
            press_d[i]  = 1'b0;
            cnt_d[i]    = '0;
            if (sync2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == DB_LAST) begin
                    stable_d[i] = ~stable_q[i];
                    press_d[i]  = ~stable_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

`ifdef KEY_REPEAT_EN
    localparam int RW = $clog2(REPEAT_CYCLES + 1);
    logic [RW-1:0] rpt_cnt_q, rpt_cnt_d;
    logic          one_held;

    assign one_held = (stable_q != 4'd0) && ((stable_q & (stable_q - 4'd1)) == 4'd0);

    always_comb begin
        rpt_cnt_d = '0;
        rpt_set   = 4'd0;
        if (one_held) begin
            if (rpt_cnt_q == RW'(REPEAT_CYCLES - 1)) begin
                rpt_set = stable_q;
            end else begin
                rpt_cnt_d = rpt_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rpt_cnt_q <= '0;
        end else begin
            rpt_cnt_q <= rpt_cnt_d;
        end
    end
`else
    logic unused_repeat_cycles;
    assign unused_repeat_cycles = ^REPEAT_CYCLES;
    assign rpt_set = 4'd0;
`endif

    assign set_req   = press_q | rpt_set;
    assign full      = (level_q == DEPTH5);
    assign valid_int = (level_q != 5'd0);
    assign pop       = valid_int && evt.ready;

    // A request landing on a bit that is being enqueued this cycle is kept, not dropped.
    always_comb begin
        grant   = 4'd0;
        wr_code = 3'd0;
        if (!full) begin
            for (int i = 0; i < 4; i++) begin
                if (pending_q[i] && (grant == 4'd0)) begin
                    grant[i] = 1'b1;
                    wr_code  = 3'(i + 1);
                end
            end
        end
        wr_en     = (grant != 4'd0);
        pending_d = (pending_q & ~grant) | set_req;
        drop      = ((set_req & pending_q & ~grant) != 4'd0);
        ovf_d     = drop ? 1'b1 : (ovf_clr ? 1'b0 : ovf_q);
        wr_ptr_d  = wr_ptr_q + AW'(wr_en);
        rd_ptr_d  = rd_ptr_q + AW'(pop);
        case ({wr_en, pop})
            2'b10:   level_d = level_q + 5'd1;
            2'b01:   level_d = level_q - 5'd1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q   <= 4'd0;
            sync2_q   <= 4'd0;
            stable_q  <= 4'd0;
            press_q   <= 4'd0;
            pending_q <= 4'd0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= 5'd0;
            ovf_q     <= 1'b0;
            for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
        end else begin
            sync1_q   <= btn_raw;
            sync2_q   <= sync1_q;
            stable_q  <= stable_d;
            press_q   <= press_d;
            pending_q <= pending_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            ovf_q     <= ovf_d;
            for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    // Storage holds data only; occupancy and pointers decide what is visible.
    always_ff @(posedge clk) begin
        if (wr_en) fifo_mem[wr_ptr_q] <= wr_code;
    end

    assign evt.valid = valid_int;
    assign evt.code  = valid_int ? fifo_mem[rd_ptr_q] : 3'd0;
    assign level     = level_q;
    assign ovf       = ovf_q;

endmodule

// File: doc/key_event_tx.md
# key_event_tx

Button front-end and event transmitter feeding the LRU recency tracker. Synchronizes and debounces the four raw push-buttons, turns each debounced press into one key code (1..4, the encoding the tracker's queue stores), buffers codes in a small FIFO, and presents them on a valid/ready stream. The tracker consumes exactly one code per accepted transfer, so presses are never lost to its slow timed clock.

## Interface
- DEBOUNCE_CYCLES, 16: consecutive cycles a synchronized input must differ from its stable value before the stable value flips; range 2..65535.
- FIFO_DEPTH, 4: event FIFO entries; power of two, 2..16.
- REPEAT_CYCLES, 1024: auto-repeat period in cycles; used only with KEY_REPEAT_EN.

- clk  input  1  sole clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- b1, b2, b3, b4  input  1 each  raw asynchronous buttons, high = pressed.
- ovf_clr  input  1  synchronous clear of ovf.
- ready  input  1  consumer accepts the current code.
- valid  output  1  code holds a buffered event.
- code  output  3  key code, 3'd1..3'd4 for b1..b4; 3'd0 when valid=0.
- level  output  5  FIFO occupancy, 0..FIFO_DEPTH.
- ovf  output  1  sticky: a press was dropped.

## Operation
- Per button: 2-flop synchronizer -> debouncer (counter + stable bit). Counter clears whenever the synchronized value equals the stable bit; when it reaches DEBOUNCE_CYCLES the stable bit flips and the counter clears.
- Press = stable bit 0->1. Release (1->0) produces no event.
- A press sets that button's pending bit. If the pending bit is already set, the press is dropped and ovf sets.
- Arbiter: each cycle with FIFO not full (level < FIFO_DEPTH, registered), the lowest-indexed set pending bit (b1 highest priority) is written to the FIFO and cleared. At most one write per cycle.
- Full FIFO: no write, pending bits hold. Pending clears only on enqueue.
- FIFO: first-word-fall-through; read and write pointers wrap modulo FIFO_DEPTH; level = writes - reads.
- Transfer occurs on a cycle with valid && ready; head pops. While valid && !ready, code and valid hold.
- Write and pop in the same cycle: both occur, level unchanged. When level = FIFO_DEPTH, a pop that cycle does not enable a write that cycle.
- ovf clears on ovf_clr; a drop in the same cycle as ovf_clr leaves ovf = 1.

## Timing
- Reset (rst low, asynchronous): valid=0, code=3'd0, level=0, ovf=0; synchronizers, stable bits, counters, pending bits, and pointers all 0. Reset mid-operation discards all buffered and pending events.
- Deassertion: sampling resumes on the first rising edge after rst rises.
- Latency, idle FIFO, no contention: raw input high and steady from before edge E gives valid=1 after edge E+DEBOUNCE_CYCLES+3. Stages:
  - synchronizer: 2 edges;
  - debounce: DEBOUNCE_CYCLES edges, stable bit flips on the last;
  - pending register: 1 edge;
  - FIFO write: 1 edge, with first-word-fall-through output.
- Throughput: one event per cycle in and out.
- Glitch shorter than DEBOUNCE_CYCLES synchronized cycles: no event.
- Simultaneous presses: the codes enqueue on consecutive cycles in b1..b4 order.

## Configuration
- KEY_REPEAT_EN defined: while exactly one stable bit is high, a repeat counter runs. Every REPEAT_CYCLES cycles after the press, it sets that button's pending bit again, with the same drop/ovf rule as a press. The counter clears on release or when more than one button is stable-high.
- KEY_REPEAT_EN undefined: no repeat logic; exactly one event per press. REPEAT_CYCLES is ignored.

## Test plan
- Reset: rst low with random buttons -> valid=0, code=0, level=0, ovf=0. Release rst, hold b3 high with ready=1 -> code=3'd3 with valid for exactly one cycle, at edge E+DEBOUNCE_CYCLES+3.
- Bounce: b2 toggling every 3 cycles for 200 cycles, then steady high -> exactly one code 3'd2. A 10-cycle pulse with DEBOUNCE_CYCLES=16 -> no event.
- Simultaneous: b1 and b4 rise on the same cycle, ready=1 -> codes 3'd1 then 3'd4 on consecutive cycles.
- Backpressure/full: ready=0, press b1,b2,b3,b4,b1 sequentially with FIFO_DEPTH=4 -> level=4, the fifth press pending, ovf=0. Press b1 again -> ovf=1. Raise ready -> stream 1,2,3,4,1. Pulse ovf_clr -> ovf=0.
- Reset mid-stream: level=3, rst low for 1 cycle -> valid=0 and level=0 immediately; no stale codes afterwards.
- KEY_REPEAT_EN, REPEAT_CYCLES=64: hold b2 for 300 cycles after the press is debounced -> 1+4 codes of 3'd2. Without the macro -> 1 code.
